// File: rtl/locked_query_ctrl.sv
// locked_query_ctrl
// Drives a combinational locked netlist as an oracle. A candidate key is
// shifted serially into a shadow register and committed atomically to the
// netlist key inputs. Query patterns arrive over a valid/ready handshake,
// are held for a programmable settle time, and the captured outputs are
// returned together with the key that produced them.
module locked_query_ctrl #(
   parameter int KEY_W  = 4,
   parameter int IN_W   = 7,
   parameter int OUT_W  = 3,
   parameter int SETTLE = 2,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_sin,
   input  logic             key_sin_valid,
   input  logic             key_commit,
   output logic             key_loaded,
   output logic [KEY_W-1:0] key_out,
   input  logic             q_valid,
   output logic             q_ready,
   input  logic [IN_W-1:0]  q_data,
   output logic [IN_W-1:0]  circ_in,
   input  logic [OUT_W-1:0] circ_out,
   output logic             r_valid,
   input  logic             r_ready,
   output logic [OUT_W-1:0] r_data,
   output logic [KEY_W-1:0] r_key,
   output logic [CNT_W-1:0] query_cnt,
   output logic             busy
);

   localparam int BC_W = $clog2(KEY_W + 1);
   localparam int SC_W = $clog2(SETTLE + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_RESULT
   } state_t;

   state_t            state;
   logic [KEY_W-1:0]  shadow;
   logic [BC_W-1:0]   bit_cnt;
   logic              pending;
   logic [SC_W-1:0]   settle_cnt;
   logic              commit_req;
   logic              commit_now;
   logic              accept;

   // A commit is only honoured once a full key has been shifted in, and it
   // only executes while idle so the key never changes under a live query.
   // Commits take priority over queries, which is why they gate q_ready.
   assign key_loaded = (bit_cnt == BC_W'(KEY_W));
   assign commit_req = key_commit & key_loaded;
   assign commit_now = (state == ST_IDLE) & (pending | commit_req);
   assign q_ready    = !rst & (state == ST_IDLE) & !(pending | commit_req);
   assign accept     = q_valid & q_ready;
   assign busy       = (state != ST_IDLE);

   // Shadow shift register, saturating bit count, pending commit and the
   // active key. A shift coinciding with a commit commits the pre-shift
   // shadow and the new bit becomes the first bit of the next key.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow  <= '0;
         bit_cnt <= '0;
         pending <= 1'b0;
         key_out <= '0;
      end else begin
         if (key_sin_valid) begin
            shadow <= {shadow[KEY_W-2:0], key_sin};
         end
         if (commit_now) begin
            key_out <= shadow;
            pending <= 1'b0;
            bit_cnt <= key_sin_valid ? BC_W'(1) : '0;
         end else begin
            if (commit_req) begin
               pending <= 1'b1;
            end
            if (key_sin_valid && !key_loaded) begin
               bit_cnt <= bit_cnt + BC_W'(1);
            end
         end
      end
   end

   // Query sequencer: apply the pattern, wait SETTLE edges, capture the
   // netlist outputs, then hold the result until the consumer takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         circ_in    <= '0;
         r_key      <= '0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         settle_cnt <= '0;
         query_cnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  circ_in    <= q_data;
                  r_key      <= key_out;
                  settle_cnt <= SC_W'(SETTLE);
                  state      <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               settle_cnt <= settle_cnt - SC_W'(1);
               if (settle_cnt == SC_W'(1)) begin
                  r_data  <= circ_out;
                  r_valid <= 1'b1;
                  state   <= ST_RESULT;
               end
            end
            ST_RESULT: begin
               if (r_ready) begin
                  r_valid   <= 1'b0;
                  query_cnt <= query_cnt + CNT_W'(1);
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_locked_query_ctrl.sv
// tb_locked_query_ctrl
// Directed scenarios plus a randomized run against a transaction-level
// reference model. A stand-in combinational locked netlist is modelled here.
module tb_locked_query_ctrl;

   localparam int KEY_W  = 4;
   localparam int IN_W   = 7;
   localparam int OUT_W  = 3;
   localparam int SETTLE = 2;
   localparam int CNT_W  = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             key_sin;
   logic             key_sin_valid;
   logic             key_commit;
   logic             key_loaded;
   logic [KEY_W-1:0] key_out;
   logic             q_valid;
   logic             q_ready;
   logic [IN_W-1:0]  q_data;
   logic [IN_W-1:0]  circ_in;
   logic [OUT_W-1:0] circ_out;
   logic             r_valid;
   logic             r_ready;
   logic [OUT_W-1:0] r_data;
   logic [KEY_W-1:0] r_key;
   logic [CNT_W-1:0] query_cnt;
   logic             busy;

   int total   = 0;
   int passed  = 0;
   int exp_cnt = 0;

   locked_query_ctrl #(
      .KEY_W(KEY_W), .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .key_sin(key_sin), .key_sin_valid(key_sin_valid), .key_commit(key_commit),
      .key_loaded(key_loaded), .key_out(key_out),
      .q_valid(q_valid), .q_ready(q_ready), .q_data(q_data),
      .circ_in(circ_in), .circ_out(circ_out),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_key(r_key),
      .query_cnt(query_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   // Stand-in locked netlist: for pattern 7'b0011011 it yields 3'b111 with
   // key 0 and 3'b110 with key 4'b1111.
   function automatic logic [OUT_W-1:0] netlist(input logic [IN_W-1:0] in,
                                                input logic [KEY_W-1:0] k);
      logic [OUT_W-1:0] o;
      o[0] = (in[0] | in[2]) ^ (&k);
      o[1] = (in[1] & in[3]) | (k[1] ^ k[2]);
      o[2] = in[4] ^ in[5] ^ in[6] ^ k[0] ^ k[3];
      return o;
   endfunction

   assign circ_out = netlist(circ_in, key_out);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      key_sin       = 1'b0;
      key_sin_valid = 1'b0;
      key_commit    = 1'b0;
      q_valid       = 1'b0;
      q_data        = '0;
      r_ready       = 1'b0;
   endtask

   task automatic shift_bit(input logic b);
      key_sin       = b;
      key_sin_valid = 1'b1;
      tick();
      key_sin_valid = 1'b0;
   endtask

   task automatic commit_key();
      key_commit = 1'b1;
      tick();
      key_commit = 1'b0;
   endtask

   // Offers a pattern, waits for acceptance, then counts edges until r_valid.
   // lat = -1 signals an expired bound.
   task automatic send_query(input logic [IN_W-1:0] d, output int lat);
      int w;
      q_valid = 1'b1;
      q_data  = d;
      #1;
      w = 0;
      while (!q_ready && w < 20) begin
         tick();
         w++;
      end
      if (!q_ready) begin
         q_valid = 1'b0;
         lat = -1;
         return;
      end
      tick();
      q_valid = 1'b0;
      lat = 0;
      while (!r_valid && lat < 20) begin
         tick();
         lat++;
      end
      if (!r_valid) lat = -1;
   endtask

   task automatic take_result();
      r_ready = 1'b1;
      tick();
      r_ready = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      key_commit = 1'b1;
      q_valid    = 1'b1;
      #1;
      total++; if (key_out !== 4'h0) $display("[TB] FAIL reset_key_out got=%0h exp=0", key_out); else passed++;
      total++; if (circ_in !== 7'h0) $display("[TB] FAIL reset_circ_in got=%0h exp=0", circ_in); else passed++;
      total++; if (key_loaded !== 1'b0) $display("[TB] FAIL reset_key_loaded got=%0b exp=0", key_loaded); else passed++;
      total++; if (q_ready !== 1'b0) $display("[TB] FAIL reset_q_ready got=%0b exp=0", q_ready); else passed++;
      total++; if (r_valid !== 1'b0) $display("[TB] FAIL reset_r_valid got=%0b exp=0", r_valid); else passed++;
      total++; if (r_data !== 3'h0 || r_key !== 4'h0) $display("[TB] FAIL reset_result got=%0h/%0h exp=0/0", r_data, r_key); else passed++;
      total++; if (query_cnt !== 16'h0 || busy !== 1'b0) $display("[TB] FAIL reset_cnt_busy got=%0h/%0b exp=0/0", query_cnt, busy); else passed++;
      clear_inputs();
      @(negedge clk);
      rst = 1'b0;
      tick();
      total++; if (q_ready !== 1'b1) $display("[TB] FAIL post_reset_q_ready got=%0b exp=1", q_ready); else passed++;
   endtask

   task automatic test_basic_query();
      int lat;
      for (int i = 0; i < 4; i++) shift_bit(1'b0);
      total++; if (key_loaded !== 1'b1) $display("[TB] FAIL basic_loaded got=%0b exp=1", key_loaded); else passed++;
      key_commit = 1'b1;
      #1;
      total++; if (q_ready !== 1'b0) $display("[TB] FAIL basic_commit_q_ready got=%0b exp=0", q_ready); else passed++;
      tick();
      key_commit = 1'b0;
      send_query(7'b0011011, lat);
      total++; if (lat !== SETTLE) $display("[TB] FAIL basic_latency got=%0d exp=%0d", lat, SETTLE); else passed++;
      total++; if (r_data !== 3'b111) $display("[TB] FAIL basic_r_data0 got=%0b exp=111", r_data); else passed++;
      total++; if (r_key !== 4'h0 || key_out !== 4'h0) $display("[TB] FAIL basic_key0 got=%0h/%0h exp=0/0", r_key, key_out); else passed++;
      take_result();
      exp_cnt++;
      total++; if (query_cnt !== 16'(exp_cnt)) $display("[TB] FAIL basic_cnt1 got=%0d exp=%0d", query_cnt, exp_cnt); else passed++;
      total++; if (circ_in !== 7'b0011011 || busy !== 1'b0) $display("[TB] FAIL basic_hold got=%0b/%0b exp=0011011/0", circ_in, busy); else passed++;

      for (int i = 0; i < 4; i++) shift_bit(1'b1);
      commit_key();
      total++; if (key_out !== 4'hF) $display("[TB] FAIL basic_key_out_f got=%0h exp=f", key_out); else passed++;
      send_query(7'b0011011, lat);
      total++; if (lat !== SETTLE) $display("[TB] FAIL basic_latency_f got=%0d exp=%0d", lat, SETTLE); else passed++;
      total++; if (r_data !== 3'b110) $display("[TB] FAIL basic_r_data_f got=%0b exp=110", r_data); else passed++;
      total++; if (r_key !== 4'hF) $display("[TB] FAIL basic_r_key_f got=%0h exp=f", r_key); else passed++;
      take_result();
      exp_cnt++;
      total++; if (query_cnt !== 16'(exp_cnt)) $display("[TB] FAIL basic_cnt2 got=%0d exp=%0d", query_cnt, exp_cnt); else passed++;
   endtask

   task automatic test_partial_key();
      shift_bit(1'b1);
      shift_bit(1'b0);
      shift_bit(1'b1);
      total++; if (key_loaded !== 1'b0) $display("[TB] FAIL partial_loaded3 got=%0b exp=0", key_loaded); else passed++;
      key_commit = 1'b1;
      #1;
      total++; if (q_ready !== 1'b1) $display("[TB] FAIL partial_q_ready got=%0b exp=1", q_ready); else passed++;
      tick();
      key_commit = 1'b0;
      tick();
      total++; if (key_out !== 4'hF) $display("[TB] FAIL partial_ignored got=%0h exp=f", key_out); else passed++;
      shift_bit(1'b0);
      total++; if (key_loaded !== 1'b1) $display("[TB] FAIL partial_loaded4 got=%0b exp=1", key_loaded); else passed++;
   endtask

   // Shadow now holds 4'b1010 while the active key is 4'b1111.
   task automatic test_commit_during_settle();
      int lat;
      logic [IN_W-1:0] p1;
      logic [IN_W-1:0] p2;
      p1 = 7'b1010101;
      p2 = 7'b0110011;
      q_valid = 1'b1;
      q_data  = p1;
      tick();
      q_valid    = 1'b0;
      key_commit = 1'b1;
      tick();
      key_commit = 1'b0;
      tick();
      total++; if (r_valid !== 1'b1) $display("[TB] FAIL mid_r_valid got=%0b exp=1", r_valid); else passed++;
      total++; if (r_key !== 4'hF || key_out !== 4'hF) $display("[TB] FAIL mid_old_key got=%0h/%0h exp=f/f", r_key, key_out); else passed++;
      total++; if (r_data !== netlist(p1, 4'hF)) $display("[TB] FAIL mid_r_data got=%0b exp=%0b", r_data, netlist(p1, 4'hF)); else passed++;
      take_result();
      exp_cnt++;
      q_valid = 1'b1;
      q_data  = p2;
      #1;
      total++; if (q_ready !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL mid_commit_cycle got=%0b/%0b exp=0/0", q_ready, busy); else passed++;
      total++; if (key_out !== 4'hF) $display("[TB] FAIL mid_key_before got=%0h exp=f", key_out); else passed++;
      tick();
      total++; if (key_out !== 4'hA || busy !== 1'b0) $display("[TB] FAIL mid_key_after got=%0h/%0b exp=a/0", key_out, busy); else passed++;
      total++; if (key_loaded !== 1'b0) $display("[TB] FAIL mid_count_cleared got=%0b exp=0", key_loaded); else passed++;
      send_query(p2, lat);
      total++; if (lat !== SETTLE) $display("[TB] FAIL mid_latency got=%0d exp=%0d", lat, SETTLE); else passed++;
      total++; if (r_key !== 4'hA) $display("[TB] FAIL mid_new_r_key got=%0h exp=a", r_key); else passed++;
      total++; if (r_data !== netlist(p2, 4'hA)) $display("[TB] FAIL mid_new_r_data got=%0b exp=%0b", r_data, netlist(p2, 4'hA)); else passed++;
      take_result();
      exp_cnt++;
   endtask

   task automatic test_backpressure();
      int lat;
      logic [IN_W-1:0] p;
      p = 7'b1100101;
      send_query(p, lat);
      total++; if (lat !== SETTLE) $display("[TB] FAIL bp_latency got=%0d exp=%0d", lat, SETTLE); else passed++;
      q_valid = 1'b1;
      q_data  = 7'h7F;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++; if (r_valid !== 1'b1 || busy !== 1'b1 || q_ready !== 1'b0) $display("[TB] FAIL bp_hold cyc=%0d got=%0b%0b%0b exp=110", i, r_valid, busy, q_ready); else passed++;
         total++; if (r_data !== netlist(p, 4'hA) || r_key !== 4'hA) $display("[TB] FAIL bp_stable cyc=%0d got=%0b/%0h exp=%0b/a", i, r_data, r_key, netlist(p, 4'hA)); else passed++;
         tick();
      end
      q_valid = 1'b0;
      r_ready = 1'b1;
      repeat (3) tick();
      r_ready = 1'b0;
      exp_cnt++;
      total++; if (query_cnt !== 16'(exp_cnt)) $display("[TB] FAIL bp_cnt_once got=%0d exp=%0d", query_cnt, exp_cnt); else passed++;
      total++; if (r_valid !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL bp_released got=%0b/%0b exp=0/0", r_valid, busy); else passed++;
   endtask

   task automatic test_back_to_back();
      logic [IN_W-1:0] p;
      p = 7'b0001111;
      q_valid = 1'b1;
      q_data  = p;
      r_ready = 1'b1;
      repeat (4 * (SETTLE + 2)) tick();
      q_valid = 1'b0;
      r_ready = 1'b0;
      exp_cnt += 4;
      total++; if (query_cnt !== 16'(exp_cnt)) $display("[TB] FAIL b2b_throughput got=%0d exp=%0d", query_cnt, exp_cnt); else passed++;
      total++; if (busy !== 1'b0 || r_data !== netlist(p, 4'hA)) $display("[TB] FAIL b2b_last got=%0b/%0b exp=0/%0b", busy, r_data, netlist(p, 4'hA)); else passed++;
   endtask

   task automatic test_async_reset();
      shift_bit(1'b1);
      shift_bit(1'b1);
      shift_bit(1'b0);
      shift_bit(1'b0);
      q_valid = 1'b1;
      q_data  = 7'h55;
      tick();
      q_valid    = 1'b0;
      key_commit = 1'b1;
      tick();
      key_commit = 1'b0;
      total++; if (busy !== 1'b1 || circ_in !== 7'h55) $display("[TB] FAIL ar_pre got=%0b/%0h exp=1/55", busy, circ_in); else passed++;
      #2;
      rst = 1'b1;
      #1;
      total++; if (r_valid !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL ar_state got=%0b/%0b exp=0/0", r_valid, busy); else passed++;
      total++; if (circ_in !== 7'h0 || key_out !== 4'h0) $display("[TB] FAIL ar_outputs got=%0h/%0h exp=0/0", circ_in, key_out); else passed++;
      total++; if (query_cnt !== 16'h0 || key_loaded !== 1'b0) $display("[TB] FAIL ar_cnt got=%0d/%0b exp=0/0", query_cnt, key_loaded); else passed++;
      @(negedge clk);
      rst = 1'b0;
      tick();
      total++; if (busy !== 1'b0 || q_ready !== 1'b1) $display("[TB] FAIL ar_idle got=%0b/%0b exp=0/1", busy, q_ready); else passed++;
      tick();
      total++; if (key_out !== 4'h0) $display("[TB] FAIL ar_commit_dropped got=%0h exp=0", key_out); else passed++;
   endtask

   // Randomized run against a transaction-level model: the key side is plain
   // arithmetic on integers, the query side tracks edges since acceptance.
   task automatic test_random();
      int m_shadow, m_bits, m_key, m_rkey, m_rdata, m_circ, m_cnt, m_age;
      logic m_pending, m_busy;
      logic exp_qr, creq, cexec, acc, done;
      clear_inputs();
      rst = 1'b1;
      #3;
      @(negedge clk);
      rst = 1'b0;
      tick();
      m_shadow = 0; m_bits = 0; m_key = 0; m_rkey = 0; m_rdata = 0;
      m_circ = 0; m_cnt = 0; m_age = 0; m_pending = 1'b0; m_busy = 1'b0;
      for (int i = 0; i < 600; i++) begin
         key_sin       = 1'($urandom_range(0, 1));
         key_sin_valid = 1'($urandom_range(0, 1));
         key_commit    = ($urandom_range(0, 4) == 0);
         q_valid       = 1'($urandom_range(0, 1));
         q_data        = 7'($urandom_range(0, 127));
         r_ready       = ($urandom_range(0, 2) != 0);
         #1;
         creq   = key_commit && (m_bits == KEY_W);
         exp_qr = !m_busy && !(m_pending || creq);
         total++; if (q_ready !== exp_qr) $display("[TB] FAIL rand_q_ready cyc=%0d got=%0b exp=%0b", i, q_ready, exp_qr); else passed++;
         total++; if (key_loaded !== (m_bits == KEY_W)) $display("[TB] FAIL rand_key_loaded cyc=%0d got=%0b exp=%0b", i, key_loaded, m_bits == KEY_W); else passed++;
         total++; if (key_out !== KEY_W'(m_key)) $display("[TB] FAIL rand_key_out cyc=%0d got=%0h exp=%0h", i, key_out, m_key); else passed++;
         total++; if (busy !== m_busy) $display("[TB] FAIL rand_busy cyc=%0d got=%0b exp=%0b", i, busy, m_busy); else passed++;
         total++; if (r_valid !== (m_busy && m_age >= SETTLE)) $display("[TB] FAIL rand_r_valid cyc=%0d got=%0b exp=%0b", i, r_valid, m_busy && m_age >= SETTLE); else passed++;
         total++; if (r_key !== KEY_W'(m_rkey) || r_data !== OUT_W'(m_rdata)) $display("[TB] FAIL rand_result cyc=%0d got=%0h/%0h exp=%0h/%0h", i, r_key, r_data, m_rkey, m_rdata); else passed++;
         total++; if (circ_in !== IN_W'(m_circ)) $display("[TB] FAIL rand_circ_in cyc=%0d got=%0h exp=%0h", i, circ_in, m_circ); else passed++;
         total++; if (query_cnt !== CNT_W'(m_cnt)) $display("[TB] FAIL rand_query_cnt cyc=%0d got=%0d exp=%0d", i, query_cnt, m_cnt); else passed++;
         cexec = !m_busy && (m_pending || creq);
         acc   = q_valid && exp_qr;
         done  = m_busy && (m_age >= SETTLE) && r_ready;
         if (acc) begin
            m_busy = 1'b1;
            m_age  = 0;
            m_circ = int'(q_data);
            m_rkey = m_key;
         end else if (done) begin
            m_busy = 1'b0;
            m_cnt  = (m_cnt + 1) % (1 << CNT_W);
         end else if (m_busy) begin
            m_age++;
            if (m_age == SETTLE) m_rdata = int'(netlist(IN_W'(m_circ), KEY_W'(m_key)));
         end
         if (cexec) begin
            m_key     = m_shadow;
            m_bits    = int'(key_sin_valid);
            m_pending = 1'b0;
         end else begin
            m_bits    = (m_bits + int'(key_sin_valid) > KEY_W) ? KEY_W : m_bits + int'(key_sin_valid);
            m_pending = m_pending || creq;
         end
         if (key_sin_valid) m_shadow = (m_shadow * 2 + int'(key_sin)) % (1 << KEY_W);
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_basic_query();
      test_partial_key();
      test_commit_during_settle();
      test_backpressure();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/locked_query_ctrl.md
# locked_query_ctrl

Sequencer that drives the locked `sample` netlist as an oracle/DUT pair during key-recovery runs. It loads a candidate key serially into a shadow register and commits it atomically to the netlist key inputs. It also applies input patterns (queries) over a valid/ready handshake, waits a programmable settle time, and returns the captured outputs with the key that produced them. It sits between the attack driver (testbench or host FSM) and the combinational locked circuit.

## Interface
- KEY_W, 4, key width; key_out[0]=key1 … key_out[3]=key4
- IN_W, 7, circuit input width; circ_in[0]=I1 … circ_in[6]=I7
- OUT_W, 3, circuit output width; circ_out[0]=O1, [1]=O2, [2]=O3
- SETTLE, 2, cycles between applying circ_in and sampling circ_out (≥1)
- CNT_W, 16, completed-query counter width

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- key_sin  in  1  serial key bit
- key_sin_valid  in  1  shift key_sin into shadow this cycle
- key_commit  in  1  request shadow→active key transfer
- key_loaded  out  1  shadow holds ≥KEY_W fresh bits
- key_out  out  KEY_W  active key to locked netlist
- q_valid / q_ready  in / out  1  query handshake
- q_data  in  IN_W  input pattern
- circ_in  out  IN_W  pattern to locked netlist
- circ_out  in  OUT_W  outputs from locked netlist
- r_valid / r_ready  out / in  1  result handshake
- r_data  out  OUT_W  captured circ_out
- r_key  out  KEY_W  key_out value in force during the query
- query_cnt  out  CNT_W  completed queries (wraps modulo 2^CNT_W)
- busy  out  1  FSM not in IDLE

## Operation
- Reset values: key_out=0, circ_in=0, shadow=0, bit count=0, key_loaded=0, commit-pending=0, state=IDLE, q_ready=0 in the reset cycle, r_valid=0, r_data=0, r_key=0, query_cnt=0, busy=0.
- Shift:
  - On key_sin_valid, shadow <= {shadow[KEY_W-2:0], key_sin}, MSB first. Shifting is allowed in any state.
  - The bit count saturates at KEY_W. key_loaded = (count==KEY_W). Extra bits keep shifting.
- Commit:
  - key_commit with key_loaded=0 is ignored.
  - key_commit with key_loaded=1 sets commit-pending.
  - The commit executes on the first IDLE cycle with pending set (including the same cycle as the request): key_out <= shadow, count <= 0, pending <= 0.
  - If a shift and a commit execute in the same cycle, the pre-shift shadow is committed and the count restarts at 1.
- FSM states IDLE, SETTLE, RESULT:
  - **IDLE:** q_ready = !(pending | (key_commit & key_loaded)). A commit always wins over a query, so key_out never changes mid-query. On q_valid&q_ready: circ_in <= q_data, r_key <= key_out, settle counter <= SETTLE, go to SETTLE.
  - **SETTLE:** counter decrements each cycle. In the cycle where counter==1: r_data <= circ_out, r_valid <= 1, go to RESULT.
  - **RESULT:** hold r_data/r_key/r_valid until r_ready. On r_valid&r_ready: r_valid <= 0, query_cnt++, go to IDLE.
- circ_in holds the last applied pattern between queries.
- busy = (state != IDLE).

## Timing
- Query accepted at edge t; circ_in is valid from cycle t+1.
- circ_out is sampled at edge t+SETTLE; r_valid is high from cycle t+SETTLE. Accept-to-result latency is SETTLE cycles (SETTLE=2 → 2).
- r_ready held high → back in IDLE one cycle after r_valid, so the next query can be accepted there. Throughput is one query per SETTLE+2 cycles.
- A commit requested while busy executes in the first IDLE cycle; q_ready is low that cycle and returns high the next cycle.
- Asynchronous reset mid-query: all outputs go to reset values immediately, and the pending result and pending commit are lost. The first cycle after release is IDLE.
- query_cnt at 2^CNT_W-1 plus one completion → 0.

## Test plan
- Shift 0,0,0,0 then commit; query q_data=7'b0011011 (I1=I2=I4=I5=1) → key_out=0, r_data=3'b111 after 2 cycles, r_key=0, query_cnt=1.
- Shift 1,1,1,1, commit, same query → key_out=4'b1111, r_data=3'b110, r_key=4'b1111.
- Shift 3 bits then key_commit → ignored, key_loaded=0, key_out unchanged. 4th bit → key_loaded=1.
- key_commit during SETTLE with a new shadow → r_key=old key. The commit lands in the first IDLE cycle with q_ready=0 that cycle, and the next query reports the new r_key.
- Hold r_ready=0 for 5 cycles → r_valid/r_data stable, q_ready=0, busy=1. Release → query_cnt increments exactly once.
- Assert rst during SETTLE → r_valid=0, circ_in=0, key_out=0, query_cnt=0 asynchronously. The pending commit is dropped and the FSM is in IDLE after release.
